// File: rtl/exa_crosb_traffic_generator_with_vcs_if.sv
// Exanet link between a packet source and a crossbar input port.
// Header, payload and footer each get their own valid/ready pair; data is shared.
interface exa_crosb_traffic_generator_with_vcs_if;
    logic         header_valid;
    logic         payload_valid;
    logic         footer_valid;
    logic [127:0] data;
    logic         header_ready;
    logic         payload_ready;
    logic         footer_ready;

    modport master (
        output header_valid, payload_valid, footer_valid, data,
        input  header_ready, payload_ready, footer_ready
    );

    modport slave (
        input  header_valid, payload_valid, footer_valid, data,
        output header_ready, payload_ready, footer_ready
    );
endinterface

// File: rtl/exa_crosb_traffic_generator_with_vcs.sv
// Exanet packet transmitter: turns descriptors into header/payload/footer words that a
// consumer can regenerate from source ID, sequence number and a free-running LFSR.
module exa_crosb_traffic_generator_with_vcs #(
    parameter logic [7:0]  P_SRC_ID   = 8'd0,
    parameter int          P_VC_NUM   = 4,
    parameter int          P_PRIO_NUM = 2,
    parameter int          P_PKT_WRAP = 128,
    parameter logic [31:0] P_SEED     = 32'hACE12345,
    localparam int         LOG_VC     = $clog2(P_VC_NUM),
    localparam int         LOG_PRIO   = $clog2(P_PRIO_NUM)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_enable,
    input  logic                     i_desc_valid,
    output logic                     o_desc_ready,
    input  logic [7:0]               i_desc_dest,
    input  logic [LOG_VC-1:0]        i_desc_vc,
    input  logic [LOG_PRIO-1:0]      i_desc_prio,
    input  logic [13:0]              i_desc_size,
    exa_crosb_traffic_generator_with_vcs_if.master exa,
    output logic [31:0]              o_pkt_count,
    output logic                     o_busy
);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, FOOTER} state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    state_t        state;
    logic [31:0]   seq;
    logic [31:0]   lfsr;
    logic [63:0]   csum;
    logic [4:0]    nwords;
    logic [4:0]    word_idx;

    logic          accept;
    logic [13:0]   size_c_in;
    logic [4:0]    nwords_in;
    logic [31:0]   seq_inc;
    logic [31:0]   hdr_seq;
    logic [127:0]  hdr_word;
    logic [31:0]   lfsr_next;
    logic [63:0]   csum_next;

    function automatic logic [127:0] payload_word(input logic [31:0] s,
                                                  input logic [4:0]  idx,
                                                  input logic [31:0] l);
        return {s, 24'd0, P_SRC_ID, 16'd0, 11'd0, idx, l};
    endfunction

    // Reset gates ready directly so nothing is accepted while reset is held.
    assign o_desc_ready = ~reset & i_enable &
                          ((state == IDLE) | ((state == FOOTER) & exa.footer_ready));
    assign accept       = i_desc_valid & o_desc_ready;
    assign o_busy       = (state != IDLE);

    assign size_c_in = (i_desc_size > 14'd256) ? 14'd256 : i_desc_size;
    assign nwords_in = (size_c_in == 14'd0) ? 5'd0 : 5'(((size_c_in - 14'd1) >> 4) + 14'd1);

    // A descriptor accepted during the footer handshake belongs to the next sequence number.
    assign seq_inc  = (seq == 32'(P_PKT_WRAP - 1)) ? 32'd0 : seq + 32'd1;
    assign hdr_seq  = (state == FOOTER) ? seq_inc : seq;
    assign hdr_word = {16'd0, P_SRC_ID, i_desc_dest, 8'(i_desc_vc), 8'(i_desc_prio),
                       18'd0, size_c_in, 16'd0, hdr_seq};

    assign lfsr_next = {1'b0, lfsr[31:1]} ^ ({32{lfsr[0]}} & LFSR_TAPS);
    assign csum_next = csum ^ exa.data[63:0];

    // Each output word is built one cycle ahead and held in exa.data until its handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            exa.header_valid  <= 1'b0;
            exa.payload_valid <= 1'b0;
            exa.footer_valid  <= 1'b0;
            exa.data          <= '0;
            seq               <= '0;
            lfsr              <= P_SEED;
            csum              <= '0;
            nwords            <= '0;
            word_idx          <= '0;
            o_pkt_count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state            <= HEADER;
                        exa.header_valid <= 1'b1;
                        exa.data         <= hdr_word;
                        nwords           <= nwords_in;
                        csum             <= '0;
                    end
                end
                HEADER: begin
                    if (exa.header_ready) begin
                        exa.header_valid <= 1'b0;
                        word_idx         <= '0;
                        if (nwords != 5'd0) begin
                            state             <= PAYLOAD;
                            exa.payload_valid <= 1'b1;
                            exa.data          <= payload_word(seq, 5'd0, lfsr);
                        end else begin
                            state            <= FOOTER;
                            exa.footer_valid <= 1'b1;
                            exa.data         <= {seq, 32'd0, csum};
                        end
                    end
                end
                PAYLOAD: begin
                    if (exa.payload_ready) begin
                        lfsr <= lfsr_next;
                        csum <= csum_next;
                        if (word_idx == nwords - 5'd1) begin
                            state             <= FOOTER;
                            exa.payload_valid <= 1'b0;
                            exa.footer_valid  <= 1'b1;
                            exa.data          <= {seq, 32'd0, csum_next};
                        end else begin
                            word_idx <= word_idx + 5'd1;
                            exa.data <= payload_word(seq, word_idx + 5'd1, lfsr_next);
                        end
                    end
                end
                FOOTER: begin
                    if (exa.footer_ready) begin
                        exa.footer_valid <= 1'b0;
                        seq              <= seq_inc;
                        o_pkt_count      <= o_pkt_count + 32'd1;
                        if (accept) begin
                            state            <= HEADER;
                            exa.header_valid <= 1'b1;
                            exa.data         <= hdr_word;
                            nwords           <= nwords_in;
                            csum             <= '0;
                        end else begin
                            state    <= IDLE;
                            exa.data <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exa_crosb_traffic_generator_with_vcs.sv
// Scoreboard bench for the exanet traffic generator: descriptors push the expected words
// of a whole packet, a negedge monitor pops and compares them at each handshake.
module tb_exa_crosb_traffic_generator_with_vcs;

    localparam logic [7:0]  SRC  = 8'h5A;
    localparam logic [31:0] SEED = 32'hACE12345;
    localparam int          WRAP = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_enable;
    logic        i_desc_valid;
    logic        o_desc_ready;
    logic [7:0]  i_desc_dest;
    logic [1:0]  i_desc_vc;
    logic [0:0]  i_desc_prio;
    logic [13:0] i_desc_size;
    logic [31:0] o_pkt_count;
    logic        o_busy;

    exa_crosb_traffic_generator_with_vcs_if exa_bus ();

    exa_crosb_traffic_generator_with_vcs #(
        .P_SRC_ID   (SRC),
        .P_VC_NUM   (4),
        .P_PRIO_NUM (2),
        .P_PKT_WRAP (WRAP),
        .P_SEED     (SEED)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (i_enable),
        .i_desc_valid (i_desc_valid),
        .o_desc_ready (o_desc_ready),
        .i_desc_dest  (i_desc_dest),
        .i_desc_vc    (i_desc_vc),
        .i_desc_prio  (i_desc_prio),
        .i_desc_size  (i_desc_size),
        .exa          (exa_bus),
        .o_pkt_count  (o_pkt_count),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           kind;
        logic [127:0] word;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_seq;
    logic [31:0] m_lfsr;
    int          m_count;
    bit          rdy_random = 1'b0;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: bound expired", name);
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        logic [31:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 32'h80200003;
        return r;
    endfunction

    task automatic model_reset();
        m_seq   = 32'd0;
        m_lfsr  = SEED;
        m_count = 0;
        sb.delete();
    endtask

    // Reference packet built straight from the field layout, one queue entry per word.
    task automatic push_packet(input logic [7:0] d, input logic [1:0] v, input logic [0:0] p, input int size);
        int           sc;
        int           nw;
        logic [127:0] w;
        logic [63:0]  cs;
        exp_t         e;
        sc = (size > 256) ? 256 : size;
        nw = (sc + 15) / 16;
        cs = 64'd0;
        w = '0;
        w[111:104] = SRC;
        w[103:96]  = d;
        w[95:88]   = {6'd0, v};
        w[87:80]   = {7'd0, p};
        w[61:48]   = 14'(sc);
        w[31:0]    = m_seq;
        e.kind = 0; e.word = w; sb.push_back(e);
        for (int k = 0; k < nw; k++) begin
            w = '0;
            w[127:96] = m_seq;
            w[71:64]  = SRC;
            w[47:32]  = 16'(k);
            w[31:0]   = m_lfsr;
            cs = cs ^ w[63:0];
            e.kind = 1; e.word = w; sb.push_back(e);
            m_lfsr = lfsr_step(m_lfsr);
        end
        w = '0;
        w[127:96] = m_seq;
        w[63:0]   = cs;
        e.kind = 2; e.word = w; sb.push_back(e);
        m_seq = (m_seq + 1) % WRAP;
        m_count++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one descriptor and waits for it to be taken; called at posedge+1.
    task automatic apply_stimulus(input logic [7:0] d, input logic [1:0] v, input logic [0:0] p,
                                  input int size, input bit keep);
        bit got;
        i_desc_dest  = d;
        i_desc_vc    = v;
        i_desc_prio  = p;
        i_desc_size  = 14'(size);
        i_desc_valid = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (o_desc_ready) begin
                push_packet(d, v, p, size);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) fail_now("desc_accept");
        if (!keep) i_desc_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !o_busy) done = 1'b1;
        end
        if (!done) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        exa_bus.header_ready  = 1'b1;
        exa_bus.payload_ready = 1'b1;
        exa_bus.footer_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_random) begin
                exa_bus.header_ready  = 1'($urandom_range(0, 1));
                exa_bus.payload_ready = 1'($urandom_range(0, 1));
                exa_bus.footer_ready  = 1'($urandom_range(0, 1));
            end else begin
                exa_bus.header_ready  = 1'b1;
                exa_bus.payload_ready = 1'b1;
                exa_bus.footer_ready  = 1'b1;
            end
        end
    end

    // Monitor: stability under stall, one-hot valids, back-to-back headers, scoreboard pops.
    initial begin
        logic [2:0]   vld;
        logic [2:0]   rdy;
        logic [2:0]   prev_vld;
        logic [127:0] prev_data;
        bit           prev_stall;
        bit           prev_b2b;
        bit           hs;
        int           kind;
        exp_t         e;
        prev_stall = 1'b0;
        prev_b2b   = 1'b0;
        prev_vld   = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            vld = {exa_bus.footer_valid, exa_bus.payload_valid, exa_bus.header_valid};
            rdy = {exa_bus.footer_ready, exa_bus.payload_ready, exa_bus.header_ready};
            if (reset) begin
                prev_stall = 1'b0;
                prev_b2b   = 1'b0;
            end else begin
                check_output("valid_onehot", 128'($countones(vld) <= 1), 128'd1);
                if (prev_stall) begin
                    check_output("stall_valid", 128'(vld), 128'(prev_vld));
                    check_output("stall_data", exa_bus.data, prev_data);
                end
                if (prev_b2b) check_output("b2b_header", 128'(exa_bus.header_valid), 128'd1);
                if (vld == 3'b000 && !o_busy) check_output("idle_data", exa_bus.data, 128'd0);
                hs = |(vld & rdy);
                if (hs) begin
                    kind = vld[0] ? 0 : (vld[1] ? 1 : 2);
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_word: got kind %0d data %h, expected nothing", kind, exa_bus.data);
                    end else begin
                        e = sb.pop_front();
                        check_output("word_kind", 128'(kind), 128'(e.kind));
                        check_output(kind == 0 ? "header_word" : (kind == 1 ? "payload_word" : "footer_word"),
                                     exa_bus.data, e.word);
                    end
                end
                prev_stall = (vld != 3'b000) && !hs;
                prev_vld   = vld;
                prev_data  = exa_bus.data;
                prev_b2b   = vld[2] & rdy[2] & i_desc_valid & o_desc_ready;
            end
        end
    end

    initial begin
        bit found;
        reset        = 1'b1;
        i_enable     = 1'b1;
        i_desc_valid = 1'b0;
        i_desc_dest  = '0;
        i_desc_vc    = '0;
        i_desc_prio  = '0;
        i_desc_size  = '0;
        model_reset();
        #2;
        check_output("rst_valids", 128'({exa_bus.header_valid, exa_bus.payload_valid, exa_bus.footer_valid}), 128'd0);
        check_output("rst_data", exa_bus.data, 128'd0);
        check_output("rst_desc_ready", 128'(o_desc_ready), 128'd0);
        check_output("rst_busy", 128'(o_busy), 128'd0);
        check_output("rst_pkt_count", 128'(o_pkt_count), 128'd0);
        tick(3);
        reset = 1'b0;
        #1;
        check_output("idle_desc_ready", 128'(o_desc_ready), 128'd1);

        // Empty packet first so the following packet's first payload word still carries the seed.
        apply_stimulus(8'd7, 2'd1, 1'b0, 0, 1'b0);
        wait_drain(100);
        apply_stimulus(8'd3, 2'd2, 1'b1, 64, 1'b0);
        wait_drain(100);
        check_output("pkt_count_two", 128'(o_pkt_count), 128'd2);
        apply_stimulus(8'd9, 2'd3, 1'b0, 1000, 1'b0);
        wait_drain(100);
        check_output("pkt_count_three", 128'(o_pkt_count), 128'd3);

        // Enable dropped during the footer handshake with a descriptor waiting.
        apply_stimulus(8'd1, 2'd0, 1'b1, 16, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (exa_bus.footer_valid) found = 1'b1;
        end
        if (!found) fail_now("footer_wait");
        #1;
        i_enable     = 1'b0;
        i_desc_valid = 1'b1;
        tick(5);
        check_output("disabled_busy", 128'(o_busy), 128'd0);
        check_output("disabled_ready", 128'(o_desc_ready), 128'd0);
        check_output("disabled_pkt_count", 128'(o_pkt_count), 128'(m_count));
        i_desc_valid = 1'b0;
        i_enable     = 1'b1;

        rdy_random = 1'b1;
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(8'($urandom), 2'($urandom), 1'($urandom), int'($urandom_range(0, 300)), 1'b0);
            tick(int'($urandom_range(0, 3)));
        end
        wait_drain(8000);
        rdy_random = 1'b0;
        check_output("random_pkt_count", 128'(o_pkt_count), 128'(m_count));

        apply_reset();
        for (int i = 0; i < 130; i++)
            apply_stimulus(8'($urandom), 2'($urandom), 1'($urandom), int'($urandom_range(0, 48)), 1'b1);
        i_desc_valid = 1'b0;
        wait_drain(200);
        check_output("b2b_pkt_count", 128'(o_pkt_count), 128'd130);

        apply_stimulus(8'd4, 2'd1, 1'b1, 200, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (exa_bus.payload_valid && exa_bus.data[47:32] == 16'd5) found = 1'b1;
        end
        if (!found) fail_now("payload5_wait");
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check_output("midrst_valids", 128'({exa_bus.header_valid, exa_bus.payload_valid, exa_bus.footer_valid}), 128'd0);
        check_output("midrst_desc_ready", 128'(o_desc_ready), 128'd0);
        check_output("midrst_busy", 128'(o_busy), 128'd0);
        tick(2);
        reset = 1'b0;
        check_output("midrst_pkt_count", 128'(o_pkt_count), 128'd0);
        apply_stimulus(8'd2, 2'd0, 1'b0, 40, 1'b0);
        wait_drain(100);
        check_output("post_rst_pkt_count", 128'(o_pkt_count), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exa_crosb_traffic_generator_with_vcs.md
# exa_crosb_traffic_generator_with_vcs

Synthesizable exanet packet transmitter that drives one crossbar input port in the VC crossbar testbench and in on-board traffic tests. It accepts packet descriptors (destination, VC, priority, size) and emits each packet as one header word, zero to sixteen payload words and one footer word on an exanet master interface. Every word is derived deterministically from the descriptor, the block's source ID, a wrapping sequence number and a 32-bit LFSR, so a downstream consumer can regenerate and check the whole packet.

## Interface
- P_SRC_ID, 0: 8-bit source ID, placed in header [111:104].
- P_VC_NUM, 4: number of virtual channels; LOG_VC = log2(P_VC_NUM).
- P_PRIO_NUM, 2: number of priorities; LOG_PRIO = log2(P_PRIO_NUM).
- P_PKT_WRAP, 128: sequence number modulus, matching the consumer's packet-memory depth.
- P_SEED, 32'hACE12345: LFSR reset value; must be non-zero.
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- i_enable  in  1  when low, no new descriptor is accepted; a packet already in flight completes.
- i_desc_valid  in  1  descriptor present.
- o_desc_ready  out  1  descriptor accepted when valid & ready.
- i_desc_dest  in  8  destination output.
- i_desc_vc  in  LOG_VC  virtual channel.
- i_desc_prio  in  LOG_PRIO  priority.
- i_desc_size  in  14  packet size in bytes.
- exa  exanet.master  —  drives header_valid, payload_valid, footer_valid, data[127:0]; samples header_ready, payload_ready, footer_ready.
- o_pkt_count  out  32  total footers sent; wraps at 2^32.
- o_busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, HEADER, PAYLOAD, FOOTER.
- o_desc_ready = i_enable & ((state==IDLE) | (state==FOOTER & footer_ready)).
- On descriptor accept, latch the fields:
  - size_c = min(i_desc_size, 256).
  - nwords = (size_c==0) ? 0 : ((size_c-1)>>4)+1, a value from 0 to 16.
- Transitions:
  - IDLE→HEADER on accept.
  - HEADER→PAYLOAD on header handshake if nwords>0; otherwise HEADER→FOOTER.
  - PAYLOAD→FOOTER on the handshake of word nwords-1.
  - FOOTER→HEADER if a new descriptor is accepted in the same cycle; otherwise FOOTER→IDLE.
- At most one of the three valid signals is high at any time: header_valid only in HEADER, payload_valid only in PAYLOAD, footer_valid only in FOOTER.
- data must stay stable while its valid is high and ready is low. data is 0 in IDLE.
- Header word fields:
  - [111:104] = P_SRC_ID
  - [103:96] = dest
  - [95:88] = vc, zero-extended
  - [87:80] = prio, zero-extended
  - [61:48] = size_c
  - [31:0] = seq
  - all other bits 0.
- Payload word k (k = 0..nwords-1): {seq[31:0], 24'd0, P_SRC_ID[7:0], 16'd0, k[15:0], lfsr[31:0]}.
- LFSR:
  - Polynomial x^32+x^22+x^2+x+1, Galois form.
  - Advances once per payload handshake; the value shown in word k is the pre-advance value.
  - It is never reset between packets.
- Footer word: {seq[31:0], 32'd0, csum[63:0]}.
  - csum is the XOR of bits [63:0] of all payload words of the packet.
  - csum = 0 when nwords = 0.
  - csum is cleared on descriptor accept.
- On the footer handshake:
  - seq ← (seq==P_PKT_WRAP-1) ? 0 : seq+1.
  - o_pkt_count ← o_pkt_count + 1.

## Timing
- Reset values: state IDLE; all valids 0; data 0; o_desc_ready 0 while reset is high; seq 0; lfsr P_SEED; o_pkt_count 0; o_busy 0.
- Reset asserted mid-packet drops all valids in the same cycle, without waiting for a clock edge; the partial packet is abandoned and is not counted.
- Descriptor accepted at edge N: header_valid is high from cycle N+1.
- Each handshake costs one cycle. With all readies held high, a packet occupies 2+nwords cycles.
- Back-to-back packets: the next header_valid is asserted in the cycle after the footer handshake, with no idle cycle.
- Ready low stalls the FSM indefinitely; no timeout.
- i_enable deasserted during the footer handshake: the FSM goes to IDLE and accepts nothing further.

## Test plan
- Reset, then descriptor size=64, dest=3, vc=2, prio=1, readies high:
  - header with [61:48]=64, [103:96]=3, [31:0]=0;
  - 4 payload words, k=0..3;
  - footer [127:96]=0;
  - o_pkt_count=1.
- size=0: header then footer on consecutive cycles; footer csum=0; the first payload word of the next packet still uses lfsr=P_SEED.
- size=1000: header [61:48]=256; exactly 16 payload words.
- Random ready deassertion, with each ready low 50% of cycles: data and valid stay stable throughout every stall; a model reconstruction of all words and csum matches.
- 130 packets back-to-back: footer seq runs 0..127, 0, 1; no idle cycle between a footer and the next header; o_pkt_count=130.
- Reset asserted during payload word 5: valids go low before the next clock edge. After release, the first packet again carries seq 0 and lfsr P_SEED, and o_pkt_count = 0.
